// File: rtl/rr_grant4_pkg.sv
// rr_grant4_pkg: shared types, constants and the rotating-priority search
// used by the four-way round-robin grant generator.
package rr_grant4_pkg;

    // Arbiter state: no owner, or one requester holds the grant.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Requester index: 2'd0 is IN1/GNT1 ... 2'd3 is IN4/GNT4.
    typedef logic [1:0] idx_t;

    // Last owner after reset is requester 4, so requester 1 is scanned first.
    localparam idx_t PTR_RESET = 2'd3;

    // Result of a priority search.
    typedef struct packed {
        logic valid;
        idx_t idx;
    } pick_t;

    // Scan req starting at ptr+1 and wrapping; ptr itself is visited last
    // and is skipped entirely when exclude is set.
    function automatic pick_t next_winner(input logic [3:0] req,
                                          input idx_t      ptr,
                                          input logic      exclude);
        pick_t res;
        idx_t  cand;
        res.valid = 1'b0;
        res.idx   = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + idx_t'(i);
            if (!res.valid && req[cand] && !(exclude && (cand == ptr))) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant4_if.sv
// rr_grant4_if: request/grant bundle between the requesters (master) and
// the round-robin grant generator (slave).
interface rr_grant4_if;
    logic IN1;
    logic IN2;
    logic IN3;
    logic IN4;
    logic DONE;
    logic GNT1;
    logic GNT2;
    logic GNT3;
    logic GNT4;
    logic Q;
    logic TOUT;

    modport master (
        output IN1, IN2, IN3, IN4, DONE,
        input  GNT1, GNT2, GNT3, GNT4, Q, TOUT
    );

    modport slave (
        input  IN1, IN2, IN3, IN4, DONE,
        output GNT1, GNT2, GNT3, GNT4, Q, TOUT
    );
endinterface

// File: rtl/rr_grant4_pick.sv
// rr_grant4_pick: combinational rotating-priority picker. Returns the first
// active request after i_ptr (wrapping), optionally excluding i_ptr itself.
module rr_grant4_pick
    import rr_grant4_pkg::*;
(
    input  logic [3:0] i_req,
    input  idx_t       i_ptr,
    input  logic       i_excl,
    output logic       o_valid,
    output idx_t       o_idx
);

    pick_t w_pick;

    assign w_pick  = next_winner(i_req, i_ptr, i_excl);
    assign o_valid = w_pick.valid;
    assign o_idx   = w_pick.idx;

endmodule

// File: rtl/rr_grant4.sv
// rr_grant4: four-way round-robin grant generator with registered one-hot
// grants, a registered "some grant active" flag Q and an optional hold
// timeout. Build option: define RR_GRANT4_TIMEOUT_EN to include the hold
// counter and the timeout-forced release (TOUT); otherwise TOUT is 0.
module rr_grant4
    import rr_grant4_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input logic          CLK,
    input logic          RST,
    rr_grant4_if.slave   bus
);

    // Reject an illegal hold limit at elaboration.
    if (HOLD_MAX < 32'sd1) begin : g_bad_hold_max
        $error("rr_grant4: HOLD_MAX must be 1 or more");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    idx_t       r_ptr;
    idx_t       w_ptr_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic       r_q;
    logic       r_tout;
    logic       w_tout_nxt;

    logic [3:0] w_req;
    logic       w_own_req;
    logic       w_timeout;
    logic       w_release;
    logic       w_pick_valid;
    idx_t       w_pick_idx;

`ifdef RR_GRANT4_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A timeout counts as the release cause only when the owner still wants
    // the grant and is not releasing it voluntarily with DONE.
    assign w_timeout = (r_state == ST_GRANT) && (r_cnt == CNT_LAST)
                       && w_own_req && !bus.DONE;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_req     = {bus.IN4, bus.IN3, bus.IN2, bus.IN1};
    assign w_own_req = w_req[r_ptr];
    assign w_release = !w_own_req || bus.DONE || w_timeout;

    // A timeout release must hand over to someone else, so the current owner
    // is excluded; otherwise the owner is simply scanned last.
    rr_grant4_pick u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_excl  (w_timeout),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Next-state, next-owner and next-output decode for the grant FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_tout_nxt  = 1'b0;
`ifdef RR_GRANT4_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_ptr_nxt   = w_pick_idx;
                    w_gnt_nxt   = 4'b0001 << w_pick_idx;
`ifdef RR_GRANT4_TIMEOUT_EN
                    w_cnt_nxt   = {CNT_W{1'b0}};
`endif
                end else begin
                    w_gnt_nxt   = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_tout_nxt = w_timeout;
                    if (w_pick_valid) begin
                        // Direct handover: old grant falls, new one rises.
                        w_state_nxt = ST_GRANT;
                        w_ptr_nxt   = w_pick_idx;
                        w_gnt_nxt   = 4'b0001 << w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                    end
`ifdef RR_GRANT4_TIMEOUT_EN
                    w_cnt_nxt = {CNT_W{1'b0}};
`endif
                end else begin
`ifdef RR_GRANT4_TIMEOUT_EN
                    if (r_cnt != CNT_SAT) begin
                        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
`endif
                    w_gnt_nxt = r_gnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = PTR_RESET;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ptr   <= PTR_RESET;
            r_gnt   <= 4'b0000;
            r_q     <= 1'b0;
            r_tout  <= 1'b0;
`ifdef RR_GRANT4_TIMEOUT_EN
            r_cnt   <= {CNT_W{1'b0}};
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_q     <= |w_gnt_nxt;
            r_tout  <= w_tout_nxt;
`ifdef RR_GRANT4_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign bus.GNT1 = r_gnt[0];
    assign bus.GNT2 = r_gnt[1];
    assign bus.GNT3 = r_gnt[2];
    assign bus.GNT4 = r_gnt[3];
    assign bus.Q    = r_q;
    assign bus.TOUT = r_tout;

endmodule

// File: tb/tb_rr_grant4.sv
// tb_rr_grant4: directed-vector bench for rr_grant4. Each observation is
// {TOUT, Q, GNT4, GNT3, GNT2, GNT1}, sampled 1 time unit after the rising edge.
module tb_rr_grant4;

`ifdef RR_GRANT4_TIMEOUT_EN
    localparam int IN3_HOLD = 3;
`else
    localparam int IN3_HOLD = 5;
`endif

    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] G1 = 6'b010001;
    localparam logic [5:0] G2 = 6'b010010;
    localparam logic [5:0] G3 = 6'b010100;
    localparam logic [5:0] G4 = 6'b011000;
    localparam logic [5:0] TO = 6'b100000;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    rr_grant4_if bus ();

    rr_grant4 #(.HOLD_MAX(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r, input logic d);
        bus.IN1  = r[0];
        bus.IN2  = r[1];
        bus.IN3  = r[2];
        bus.IN4  = r[3];
        bus.DONE = d;
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bus.TOUT, bus.Q, bus.GNT4, bus.GNT3, bus.GNT2, bus.GNT1};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        set_req(4'b0000, 1'b0);
        tick();
        check("reset", Z);

        // Full load, DONE every cycle: 1,2,3,4,1 on consecutive edges.
        rst = 1'b0;
        set_req(4'b1111, 1'b1);
        tick(); check("rot_g1", G1);
        tick(); check("rot_g2", G2);
        tick(); check("rot_g3", G3);
        tick(); check("rot_g4", G4);
        tick(); check("rot_g1b", G1);
        set_req(4'b0000, 1'b0);
        tick(); check("rot_idle", Z);

        // IN3 alone: grant after one edge, drop one edge after IN3 falls.
        set_req(4'b0100, 1'b0);
        for (int i = 0; i < IN3_HOLD; i++) begin
            tick(); check("in3_hold", G3);
        end
        set_req(4'b0000, 1'b0);
        tick(); check("in3_drop", Z);

        // DONE with no request is ignored in IDLE.
        set_req(4'b0000, 1'b1);
        tick(); check("done_idle", Z);

        // Waiting request is kept and handed over with no bubble.
        set_req(4'b0001, 1'b0);
        tick(); check("wait_g1", G1);
        set_req(4'b0011, 1'b0);
        tick(); check("wait_hold", G1);
        set_req(4'b0010, 1'b0);
        tick(); check("wait_g2", G2);

        // Reach GNT2 under full load, then reset mid-grant.
        set_req(4'b1111, 1'b1);
        tick(); check("pre_g3", G3);
        tick(); check("pre_g4", G4);
        tick(); check("pre_g1", G1);
        tick(); check("pre_g2", G2);
        set_req(4'b1111, 1'b0);
        rst = 1'b1;
        tick(); check("rst_mid", Z);
        rst = 1'b0;
        tick(); check("rst_g1", G1);
        set_req(4'b1111, 1'b1);
        tick(); check("rst_g2", G2);
        set_req(4'b0000, 1'b0);
        tick(); check("rst_idle", Z);

`ifdef RR_GRANT4_TIMEOUT_EN
        // HOLD_MAX=4, IN2 and IN4 held: 4 cycles each, TOUT at handovers.
        rst = 1'b1;
        tick(); check("to_rst", Z);
        rst = 1'b0;
        set_req(4'b1010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); check("to_g2", G2);
        end
        tick(); check("to_g4_tout", G4 | TO);
        for (int i = 0; i < 3; i++) begin
            tick(); check("to_g4", G4);
        end
        tick(); check("to_g2_tout", G2 | TO);

        // Only IN1 held: 4 cycles granted, one idle cycle with TOUT, regrant.
        set_req(4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); check("to1_g1", G1);
        end
        tick(); check("to1_gap", TO);
        tick(); check("to1_regrant", G1);
`else
        // IN1 held 50 cycles with no DONE: never released, no TOUT.
        set_req(4'b0001, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick(); check("hold50", G1);
        end
        set_req(4'b0000, 1'b0);
        tick(); check("hold50_drop", Z);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_grant4.md
# rr_grant4

Four-way round-robin grant generator for the cell-level power-test harness. It takes four request lines and returns one-hot registered grants, the reverse of an OR4 reduction: it resolves which of the four ORed requesters owns the shared path. A registered aggregate `Q` reports that some grant is active. An optional hold timeout keeps any single requester from monopolising the grant.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles one requester may hold a grant when the timeout is compiled in; legal range is 1 or more.
- `CLK` input, 1 bit: the single clock; all state updates on the rising edge.
- `RST` input, 1 bit: synchronous reset, active-high.
- `IN1`..`IN4` input, 1 bit each: request lines; level-sensitive.
- `DONE` input, 1 bit: current owner releases its grant.
- `GNT1`..`GNT4` output, 1 bit each: registered one-hot grants.
- `Q` output, 1 bit: registered OR of `GNT1`..`GNT4`.
- `TOUT` output, 1 bit: one-cycle pulse on a timeout-forced release.

## Operation
- Reset values:
  - All `GNTn`, `Q` and `TOUT` are 0.
  - State is IDLE.
  - Last-owner pointer is 4, so `IN1` has first priority.
  - Hold counter is 0.
- State IDLE:
  - If any `INn` is high at an edge, grant the first requester scanning from pointer+1 upward, wrapping 4 to 1.
  - Set pointer to the winner and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT, owner k. A release happens at an edge when any of these holds:
  - `INk` is low;
  - `DONE` is high;
  - a timeout fires (hold counter = `HOLD_MAX`-1, timeout build only).
- On release, choose the next winner from the other three requests, scanning from k+1 with wrap.
  - If a winner exists, hand the grant over directly with no bubble, set the pointer, and clear the counter.
  - If none exists, go to IDLE with all grants 0.
  - A non-timeout release with only `INk` still high re-grants k directly with no bubble and clears the counter.
  - A timeout with only `INk` high goes to IDLE for one cycle, then re-grants k.
- If there is no release, hold the grant and increment the counter, saturating.
- `DONE` is ignored in IDLE.
- Requests arriving while a grant is held wait; they are never dropped.
- Grants are never more than one-hot.

## Timing
- Request-to-grant latency is one cycle: a request sampled at edge t gives a grant visible after edge t.
- Release-to-next-grant is zero cycles: the old grant falls and the new grant rises on the same edge.
- `Q` changes on the same edge as the grants.
- `TOUT` is high for exactly the cycle following the forced-release edge.
- `RST` asserted mid-grant clears everything at that edge; requests at that same edge are ignored.
- `HOLD_MAX`=1 forces every grant to last one cycle and rotates each cycle under full load.
- The counter is `$clog2(HOLD_MAX+1)` bits wide and cannot wrap.

## Configuration
- Macro `RR_GRANT4_TIMEOUT_EN`.
- Defined: the hold counter and timeout release are built, and `TOUT` is driven as specified.
- Undefined:
  - The counter is removed and `HOLD_MAX` is unused.
  - Release happens only when `INk` drops or on `DONE`.
  - `TOUT` is tied to 0.

## Structure
- Package `rr_grant4_pkg` holds:
  - the state enum (IDLE, GRANT);
  - the 2-bit requester index type;
  - the pointer reset constant;
  - the `next_winner(req, ptr, exclude)` function.
- One sub-module, `rr_grant4_pick`: a combinational rotating-priority picker.
  - Inputs: 4-bit request vector, pointer, exclude-current flag.
  - Outputs: valid and index.
- The top module holds the state register, pointer, counter and output registers.

## Test plan
- Reset, then `IN1`..`IN4` all high and held, with `DONE` pulsed every cycle: grants go `GNT1`,2,3,4,1 on consecutive cycles and `Q` stays 1.
- `IN3` alone for 5 cycles, then low: `GNT3` rises 1 cycle after the request and falls on the edge after `IN3` drops; `Q` follows.
- Timeout build with `HOLD_MAX`=4, `IN2`=`IN4`=1 held: `GNT2` lasts 4 cycles, then `GNT4` for 4 cycles. `TOUT` pulses at each handover.
- Timeout build with `HOLD_MAX`=4, only `IN1` held high: grant is 1 for 4 cycles, then 0 for 1 cycle with `TOUT`=1, then 1 again.
- `RST`=1 during `GNT2` with all requests high: after the edge all outputs are 0. After `RST` drops, `GNT1` is granted first.
- Non-timeout build, `IN1` held for 50 cycles with no `DONE`: `GNT1` stays high throughout and `TOUT` stays 0.
